uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the team's uart_tx.
- Synchronises the asynchronous serial input.
- Qualifies the start bit and samples each bit at mid-bit.
- Checks the stop bit.
- Presents each received byte through a one-entry valid/ready holding register.
- Sits between the board RX pin and the command/stream parser; shares CLKS_PER_BIT with uart_tx.

Parameters:
- CLKS_PER_BIT, 87, system clocks per bit period (legal range 4..255); H = (CLKS_PER_BIT-1)/2 (integer division) is the mid-bit offset.

Ports:
- i_Clock  in  1  system clock, all logic on posedge
- i_Reset  in  1  reset, synchronous, active-high
- i_Rx_Serial  in  1  asynchronous serial line, idle high
- i_Rx_Ready  in  1  consumer accepts o_Rx_Byte when high with o_Rx_Valid
- o_Rx_Valid  out  1  holding register contains an unconsumed byte
- o_Rx_Byte  out  8  received byte, LSB first on the line
- o_Rx_Busy  out  1  receive FSM not in IDLE
- o_Frame_Err  out  1  one-cycle pulse: stop bit sampled low
- o_Overrun  out  1  one-cycle pulse: byte completed while holding register full and not being read

Behaviour:
- Decided: one clock (i_Clock); reset i_Reset is synchronous and active-high.

Reset (i_Reset high at a posedge):
- FSM goes to IDLE; counters and bit index go to 0.
- Both synchroniser flops go to 1.
- o_Rx_Valid, o_Rx_Byte, o_Frame_Err and o_Overrun go to 0.
- Reset mid-frame abandons the frame silently.

Synchroniser and counting:
- rx_s is the output of a 2-flop synchroniser on i_Rx_Serial; all FSM decisions use rx_s.
- A single clock counter spans 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- The bit index is 3 bits.

FSM states:
- IDLE: count=0, index=0. If rx_s==0, go to START.
- START: count increments. At count==H, sample rx_s:
  - 0: count<=0, go to DATA.
  - 1 (glitch): go to IDLE, no outputs.
- DATA: count increments. At count==CLKS_PER_BIT-1, count<=0 and shift rx_s into shreg[index].
  - index<7: index++.
  - index==7: go to STOP.
- STOP: at count==CLKS_PER_BIT-1, sample rx_s:
  - 1: deliver, then go to IDLE.
  - 0: pulse o_Frame_Err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from retriggering.

Timing:
- T0 is the first posedge that samples i_Rx_Serial low.
- IDLE→START occurs at edge T0+2.
- Data bit i is sampled at edge T0+3+H+CLKS_PER_BIT*(i+1).
- The stop bit is sampled at edge T0+3+H+9*CLKS_PER_BIT.
- Delivery and the error pulses are registered on that same edge.

Deliver (holding register):
- If o_Rx_Valid==0, or i_Rx_Ready==1 in that same cycle: load o_Rx_Byte <= shreg, o_Rx_Valid <= 1. A simultaneous handshake is not an overrun.
- Otherwise keep the old byte, drop the new byte, pulse o_Overrun.

Consume:
- o_Rx_Valid && i_Rx_Ready with no delivery: o_Rx_Valid <= 0 on the next edge.
- o_Rx_Byte holds its last value after consumption.

Other outputs:
- o_Rx_Busy is combinational (state != IDLE).
- o_Frame_Err and o_Overrun are never asserted in the same cycle as each other.

Decomposition:
- Shared package uart_pkg, also used by uart_tx:
  - state enum for rx (IDLE, START, DATA, STOP, WAIT_HIGH);
  - UART_DATA_BITS=8;
  - default CLKS_PER_BIT constant.
- One sub-module: uart_sync, a 2-flop synchroniser with synchronous reset to 1.

Test Plan (CLKS_PER_BIT=8, H=3):
- Frame 0xA5, i_Rx_Ready=1 → o_Rx_Valid rises at edge T0+78 with o_Rx_Byte=0xA5; low next cycle; o_Rx_Busy low after T0+78.
- Line low for 2 clocks then high → o_Rx_Busy high for about 5 cycles, then IDLE; no o_Rx_Valid, no o_Frame_Err.
- Frame 0x3C with stop bit 0, line held low 20 more cycles → o_Frame_Err pulses once at T0+78; no o_Rx_Valid; FSM stays in WAIT_HIGH until the line rises, then a following 0x5A is received correctly.
- Back-to-back 0x00 then 0xFF, i_Rx_Ready=0 → o_Rx_Byte stays 0x00 with o_Rx_Valid=1; o_Overrun pulses once at completion of 0xFF.
- Repeat the previous case with i_Rx_Ready pulsed high exactly in the 0xFF completion cycle → o_Rx_Byte=0xFF, o_Rx_Valid=1, no o_Overrun.
- i_Reset asserted one cycle during data bit 4 of 0x81 → all outputs 0, no delivery; after the line idles, the next frame 0x81 is received with correct latency.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_rx and uart_tx.
// Contents:
//   - receive FSM state type;
//   - number of data bits per frame;
//   - default clocks-per-bit.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int CLKS_PER_BIT_DEF = 87;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte hand-off between the UART receiver and its consumer.
// Signals:
//   rx_valid - holding register contains an unconsumed byte (receiver drives)
//   rx_byte  - received byte (receiver drives)
//   rx_ready - consumer accepts rx_byte while rx_valid is high (consumer drives)
// Modports:
//   master - the receiver side
//   slave  - the consumer side
interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx_valid;
  logic                      rx_ready;
  logic [UART_DATA_BITS-1:0] rx_byte;

  modport master (output rx_valid, output rx_byte, input rx_ready);
  modport slave  (input rx_valid, input rx_byte, output rx_ready);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both flops reset to 1 so that a reset never looks like a start bit.
// Ports:
//   i_Clock - system clock
//   i_Reset - synchronous, active-high reset
//   i_Async - asynchronous input
//   o_Sync  - synchronised copy of i_Async, two clocks late
module uart_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      meta_p0 <= i_Async;
      sync_p1 <= meta_p0;
    end
  end

  assign o_Sync = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Ports:
//   i_Clock     - system clock, all logic on posedge
//   i_Reset     - synchronous, active-high reset
//   i_Rx_Serial - asynchronous serial line, idle high
//   rx_if       - byte hand-off (rx_valid / rx_byte out, rx_ready in)
//   o_Rx_Busy   - receive FSM not in IDLE
//   o_Frame_Err - one-cycle pulse: stop bit sampled low
//   o_Overrun   - one-cycle pulse: byte completed while holding register
//                 full and not being read; the new byte is dropped
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Rx_Serial,
  uart_rx_if.master     rx_if,
  output logic          o_Rx_Busy,
  output logic          o_Frame_Err,
  output logic          o_Overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // Mid-bit offset: the start bit is confirmed here, after which every
  // full bit period lands in the middle of the next bit.
  localparam logic [CW-1:0] H_C    = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      stop_ok, stop_bad;

  uart_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (rx_s)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == H_C) begin
          cnt_d   = '0;
          // A line that is high again at mid start bit was a glitch.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line returns high so a break is not
        // mistaken for a stream of start bits.
        cnt_d = '0;
        idx_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Holding register: a delivery coinciding with a read replaces the byte.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_if.rx_valid <= 1'b0;
      rx_if.rx_byte  <= '0;
      o_Frame_Err    <= 1'b0;
      o_Overrun      <= 1'b0;
    end else begin
      o_Frame_Err <= stop_bad;
      o_Overrun   <= 1'b0;
      if (stop_ok) begin
        if (!rx_if.rx_valid || rx_if.rx_ready) begin
          rx_if.rx_byte  <= shreg_q;
          rx_if.rx_valid <= 1'b1;
        end else begin
          o_Overrun <= 1'b1;
        end
      end else if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid <= 1'b0;
      end
    end
  end

  assign o_Rx_Busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic busy, fe, ov;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Rx_Serial (rx),
    .rx_if       (u_if),
    .o_Rx_Busy   (busy),
    .o_Frame_Err (fe),
    .o_Overrun   (ov)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Event recorder: edge number and pulse counters, sampled 1 unit after each edge.
  int   cyc = 0;
  int   n_vrise = 0, vrise_cyc = -1, n_vhi = 0;
  int   n_fe = 0, fe_cyc = -1, n_ov = 0, ov_cyc = -1;
  int   n_busy = 0, n_both = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (u_if.rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      n_vrise   = n_vrise + 1;
      vrise_cyc = cyc;
    end
    if (u_if.rx_valid === 1'b1) n_vhi = n_vhi + 1;
    prev_valid = u_if.rx_valid;
    if (fe === 1'b1) begin n_fe = n_fe + 1; fe_cyc = cyc; end
    if (ov === 1'b1) begin n_ov = n_ov + 1; ov_cyc = cyc; end
    if (fe === 1'b1 && ov === 1'b1) n_both = n_both + 1;
    if (busy === 1'b1) n_busy = n_busy + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives ncyc clocks of an 8N1 frame; t0 is the first edge that sees the start bit.
  // pulse_k >= 0 raises rx_ready only for edge t0+pulse_k.
  task automatic send_frame(input logic [7:0] b, input logic stopv, input int pulse_k,
                            input int ncyc, output int t0);
    int bi;
    t0 = cyc + 1;
    for (int k = 0; k < ncyc; k++) begin
      bi = k / CPB;
      if (bi == 0)      rx = 1'b0;
      else if (bi <= 8) rx = b[bi-1];
      else              rx = stopv;
      if (pulse_k >= 0) u_if.rx_ready = (k == pulse_k);
      tick();
    end
  endtask

  int t0, t0b, v0, vh0, f0, o0, b0;

  initial begin
    u_if.rx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("rst_byte",  {24'd0, u_if.rx_byte}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_fe",    {31'd0, fe}, 32'd0);
    chk("rst_ov",    {31'd0, ov}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // Plain frame 0xA5 with consumer always ready
    u_if.rx_ready = 1'b1;
    v0 = n_vrise; vh0 = n_vhi; f0 = n_fe;
    send_frame(8'hA5, 1'b1, -1, 10*CPB, t0);
    chk("a5_rises",   n_vrise - v0, 1);
    chk("a5_latency", vrise_cyc, t0 + 78);
    chk("a5_byte",    {24'd0, u_if.rx_byte}, 32'hA5);
    chk("a5_vwidth",  n_vhi - vh0, 1);
    chk("a5_valid_lo", {31'd0, u_if.rx_valid}, 32'd0);
    chk("a5_busy_lo", {31'd0, busy}, 32'd0);
    chk("a5_no_fe",   n_fe - f0, 0);

    // Two-clock glitch on an idle line
    repeat (4) tick();
    v0 = n_vrise; f0 = n_fe; b0 = n_busy;
    rx = 1'b0;
    tick(); tick();
    rx = 1'b1;
    repeat (20) tick();
    chk("gl_busy_cycles", n_busy - b0, 4);
    chk("gl_no_valid", n_vrise - v0, 0);
    chk("gl_no_fe",    n_fe - f0, 0);
    chk("gl_busy_lo",  {31'd0, busy}, 32'd0);

    // Frame error on 0x3C, line held low afterwards (break)
    v0 = n_vrise; f0 = n_fe;
    send_frame(8'h3C, 1'b0, -1, 10*CPB, t0);
    rx = 1'b0;
    repeat (20) tick();
    chk("fe_count",    n_fe - f0, 1);
    chk("fe_cycle",    fe_cyc, t0 + 78);
    chk("fe_no_valid", n_vrise - v0, 0);
    chk("fe_wait_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (4) tick();
    chk("fe_idle_again", {31'd0, busy}, 32'd0);
    chk("fe_single", n_fe - f0, 1);
    send_frame(8'h5A, 1'b1, -1, 10*CPB, t0);
    chk("5a_latency", vrise_cyc, t0 + 78);
    chk("5a_byte",    {24'd0, u_if.rx_byte}, 32'h5A);

    // Back-to-back 0x00, 0xFF with no reader: overrun
    repeat (4) tick();
    u_if.rx_ready = 1'b0;
    v0 = n_vrise; o0 = n_ov;
    send_frame(8'h00, 1'b1, -1, 10*CPB, t0);
    send_frame(8'hFF, 1'b1, -1, 10*CPB, t0b);
    chk("ov_first_lat", vrise_cyc, t0 + 78);
    chk("ov_rises",     n_vrise - v0, 1);
    chk("ov_valid",     {31'd0, u_if.rx_valid}, 32'd1);
    chk("ov_byte_kept", {24'd0, u_if.rx_byte}, 32'h00);
    chk("ov_count",     n_ov - o0, 1);
    chk("ov_cycle",     ov_cyc, t0b + 78);
    u_if.rx_ready = 1'b1;
    tick();
    u_if.rx_ready = 1'b0;
    chk("ov_consumed", {31'd0, u_if.rx_valid}, 32'd0);

    // Same, but the reader accepts exactly in the completion cycle of 0xFF
    repeat (4) tick();
    o0 = n_ov;
    send_frame(8'h00, 1'b1, -1, 10*CPB, t0);
    send_frame(8'hFF, 1'b1, 78, 10*CPB, t0b);
    chk("hs_byte",  {24'd0, u_if.rx_byte}, 32'hFF);
    chk("hs_valid", {31'd0, u_if.rx_valid}, 32'd1);
    chk("hs_no_ov", n_ov - o0, 0);

    // Reset during data bit 4 of 0x81
    repeat (4) tick();
    v0 = n_vrise; f0 = n_fe;
    send_frame(8'h81, 1'b1, -1, 43, t0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx  = 1'b1;
    chk("mr_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("mr_byte",  {24'd0, u_if.rx_byte}, 32'd0);
    chk("mr_busy",  {31'd0, busy}, 32'd0);
    chk("mr_fe",    {31'd0, fe}, 32'd0);
    chk("mr_ov",    {31'd0, ov}, 32'd0);
    repeat (20) tick();
    chk("mr_no_delivery", n_vrise - v0, 0);
    chk("mr_no_fe",       n_fe - f0, 0);
    u_if.rx_ready = 1'b1;
    send_frame(8'h81, 1'b1, -1, 10*CPB, t0);
    chk("81_latency", vrise_cyc, t0 + 78);
    chk("81_byte",    {24'd0, u_if.rx_byte}, 32'h81);
    chk("81_valid_lo", {31'd0, u_if.rx_valid}, 32'd0);

    chk("fe_ov_exclusive", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
